// File: rtl/lif_scheduler_if.sv
// Tick/spike channel between the input-current producer, the LIF scheduler
// and the spike consumer.
//   tick_valid/tick_ready : tick handshake, currents held by producer until accepted
//   currents              : flattened per-neuron currents, neuron i at [i*WIDTH +: WIDTH]
//   spikes/spike_valid    : spike vector of the last completed tick, one-cycle pulse
interface lif_scheduler_if #(
  parameter int NUM_NEURONS = 8,
  parameter int WIDTH       = 8
);
  logic                          tick_valid;
  logic                          tick_ready;
  logic [NUM_NEURONS*WIDTH-1:0]  currents;
  logic [NUM_NEURONS-1:0]        spikes;
  logic                          spike_valid;

  modport master (output tick_valid, currents, input tick_ready, spikes, spike_valid);
  modport slave  (input tick_valid, currents, output tick_ready, spikes, spike_valid);
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire scheduler. One shared update
// datapath sweeps NUM_NEURONS virtual neurons, one per cycle, per accepted
// tick, then publishes the tick's spike vector with a one-cycle pulse.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   tick            : tick/spike channel (slave side)
//   cfg_we, cfg_threshold, cfg_shift : shared config, written only while idle
//   rd_addr/rd_data : registered membrane readout (0 for out-of-range index)
//   busy            : sweep or publish in progress
module lif_scheduler #(
  parameter int NUM_NEURONS       = 8,
  parameter int WIDTH             = 8,
  parameter int DEFAULT_THRESHOLD = 127,
  parameter int DEFAULT_SHIFT     = 1,
  localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  lif_scheduler_if.slave   tick,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_threshold,
  input  logic [2:0]       cfg_shift,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

  state_t                              state, state_nxt;
  logic [AW-1:0]                       idx;
  logic [NUM_NEURONS-1:0][WIDTH-1:0]   mem;
  logic [NUM_NEURONS-1:0][WIDTH-1:0]   cur_sh;   // currents captured at acceptance
  logic [NUM_NEURONS-1:0]              acc;      // spikes of the tick in progress
  logic [WIDTH-1:0]                    threshold;
  logic [2:0]                          shift;

  logic [WIDTH-1:0] mem_i, cur_i, leaked, sum_sat;
  logic [WIDTH:0]   sum;
  logic             fire;

  assign tick.tick_ready = rst_n && (state == IDLE);
  assign busy            = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick.tick_valid) state_nxt = RUN;
      RUN:     if (idx == LAST)     state_nxt = DONE;
      DONE:                         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Shared update datapath for neuron idx
  always_comb begin
    mem_i = mem[idx];
    cur_i = cur_sh[idx];
    if (shift == 3'd0)              leaked = '0;
    else if (int'(shift) >= WIDTH)  leaked = mem_i;
    else                            leaked = mem_i - (mem_i >> shift);
    sum     = {1'b0, leaked} + {1'b0, cur_i};
    sum_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    fire    = (sum_sat >= threshold);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      mem              <= '0;
      cur_sh           <= '0;
      acc              <= '0;
      threshold        <= WIDTH'(DEFAULT_THRESHOLD);
      shift            <= 3'(DEFAULT_SHIFT);
      tick.spikes      <= '0;
      tick.spike_valid <= 1'b0;
      rd_data          <= '0;
    end else begin
      state            <= state_nxt;
      tick.spike_valid <= 1'b0;
      // mem is read before this edge's update, so same-cycle reads see old value
      rd_data <= (int'(rd_addr) < NUM_NEURONS) ? mem[rd_addr] : '0;
      case (state)
        IDLE: begin
          // config lands on the acceptance edge too, so it applies to that tick
          if (cfg_we) begin
            threshold <= cfg_threshold;
            shift     <= cfg_shift;
          end
          if (tick.tick_valid) begin
            cur_sh <= tick.currents;
            idx    <= '0;
            acc    <= '0;
          end
        end
        RUN: begin
          if (fire) begin
            acc[idx] <= 1'b1;
            mem[idx] <= '0;
          end else begin
            mem[idx] <= sum_sat;
          end
          if (idx != LAST) idx <= idx + 1'b1;
        end
        DONE: begin
          tick.spikes      <= acc;
          tick.spike_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
module tb_lif_scheduler;
  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [W-1:0] cfg_threshold;
  logic [2:0]   cfg_shift;
  logic [2:0]   rd_addr;
  logic [W-1:0] rd_data;
  logic         busy;

  lif_scheduler_if #(.NUM_NEURONS(N), .WIDTH(W)) bus ();

  lif_scheduler #(.NUM_NEURONS(N), .WIDTH(W), .DEFAULT_THRESHOLD(127), .DEFAULT_SHIFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(bus.slave),
    .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_shift(cfg_shift),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] spk; int cyc; } exp_t;
  exp_t         exp_q[$];
  int           tests = 0, fails = 0;
  int           cyc = 0;
  int           mem_m[N];
  int           thr_m = 127, sh_m = 1;
  logic [N-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: one whole tick at once, straight from the LIF rules
  function automatic logic [N-1:0] model_tick(input logic [N*W-1:0] cur);
    logic [N-1:0] spk = '0;
    for (int i = 0; i < N; i++) begin
      int m = mem_m[i];
      int lk, s;
      if (sh_m == 0)      lk = 0;
      else if (sh_m >= W) lk = m;
      else                lk = m - m / (1 << sh_m);
      s = lk + int'(cur[i*W +: W]);
      if (s > 255) s = 255;
      if (s >= thr_m) begin spk[i] = 1'b1; mem_m[i] = 0; end
      else mem_m[i] = s;
    end
    return spk;
  endfunction

  // Monitor: scoreboard pops on each spike_valid; also handshake sanity
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("ready_in_reset", int'(bus.tick_ready), 0);
      last_exp <= '0;
    end else begin
      chk("ready_vs_busy", int'(bus.tick_ready), int'(!busy));
      if (bus.spike_valid) begin
        if (exp_q.size() == 0) chk("unexpected_spike_valid", 1, 0);
        else begin
          chk("spikes", int'(bus.spikes), int'(exp_q[0].spk));
          chk("spike_valid_cycle", cyc, exp_q[0].cyc);
          last_exp <= exp_q[0].spk;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("spikes_hold", int'(bus.spikes), int'(last_exp));
        if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
          chk("spike_valid_missing", cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_tick(input logic [N*W-1:0] cur, input bit wcfg, input int thr, input int sh,
                         output int accedge);
    bit got = 0;
    bus.tick_valid = 1'b1; bus.currents = cur;
    cfg_we = wcfg; cfg_threshold = W'(thr); cfg_shift = 3'(sh);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.tick_ready) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    accedge = cyc + 1;
    if (wcfg) begin thr_m = thr; sh_m = sh; end
    exp_q.push_back('{model_tick(cur), accedge + N + 1});
    @(posedge clk); #1;
    bus.tick_valid = 1'b0; cfg_we = 1'b0;
    bus.currents = {$urandom, $urandom};   // must not disturb the sweep
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.tick_ready) begin got = 1; break; end
    end
    if (!got) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic cfg_idle(input int thr, input int sh);
    cfg_we = 1'b1; cfg_threshold = W'(thr); cfg_shift = 3'(sh);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    thr_m = thr; sh_m = sh;
  endtask

  task automatic check_mem();
    for (int i = 0; i < N; i++) begin
      rd_addr = 3'(i);
      @(posedge clk); #1;
      chk($sformatf("mem%0d", i), int'(rd_data), mem_m[i]);
    end
  endtask

  initial begin
    int a0, a1, a2, rel;
    logic [N*W-1:0] cur;
    for (int i = 0; i < N; i++) mem_m[i] = 0;
    rst_n = 1'b0; bus.tick_valid = 1'b0; bus.currents = '0;
    cfg_we = 1'b0; cfg_threshold = '0; cfg_shift = '0; rd_addr = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_spike_valid", int'(bus.spike_valid), 0);
    chk("rst_spikes", int'(bus.spikes), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all-zero tick
    do_tick('0, 0, 0, 0, a0); wait_idle(); check_mem();

    // neuron 0 current 100, defaults: no spike then spike
    cur = '0; cur[7:0] = 8'd100;
    do_tick(cur, 0, 0, 0, a0); wait_idle();
    chk("n0_tick1_spike", int'(bus.spikes[0]), 0);
    do_tick(cur, 0, 0, 0, a0); wait_idle();
    chk("n0_tick2_spike", int'(bus.spikes[0]), 1);
    check_mem();

    // saturation: thr 255, shift 7, neuron 3 current 200 twice
    cfg_idle(255, 7);
    cur = '0; cur[3*W +: W] = 8'd200;
    do_tick(cur, 0, 0, 0, a0); do_tick(cur, 0, 0, 0, a0); wait_idle();
    chk("sat_spike3", int'(bus.spikes[3]), 1);
    check_mem();

    // config write during RUN is ignored
    do_tick('0, 0, 0, 0, a0);
    @(posedge clk); #1;
    chk("busy_in_run", int'(busy), 1);
    cfg_we = 1'b1; cfg_threshold = '0; cfg_shift = 3'd1;
    @(posedge clk); #1; cfg_we = 1'b0;
    wait_idle();
    chk("gated_cfg_no_spikes", int'(bus.spikes), 0);
    cfg_idle(0, 1);
    do_tick('0, 0, 0, 0, a0); wait_idle();
    chk("thr0_all_spike", int'(bus.spikes), 255);

    // backpressure: three back-to-back ticks, config on acceptance edge
    do_tick({$urandom, $urandom}, 1, 200, 2, a0);
    do_tick({$urandom, $urandom}, 0, 0, 0, a1);
    do_tick({$urandom, $urandom}, 1, 150, 3, a2);
    chk("gap1", a1 - a0, N + 2);
    chk("gap2", a2 - a1, N + 2);
    wait_idle(); check_mem();

    // reset mid-sweep
    do_tick({$urandom, $urandom}, 0, 0, 0, a0);
    @(posedge clk); #1; @(posedge clk); #1;   // now just after edge T+2
    @(posedge clk); #1;                       // just after edge T+3
    rst_n = 1'b0; exp_q.delete();
    for (int i = 0; i < N; i++) mem_m[i] = 0;
    thr_m = 127; sh_m = 1;
    cur = '0; cur[7:0] = 8'd127; cur[15:8] = 8'd126;
    bus.tick_valid = 1'b1; bus.currents = cur;
    @(posedge clk); #1;                       // edge T+4 resets
    @(posedge clk); #1;
    rst_n = 1'b1; rel = cyc;
    do_tick(cur, 0, 0, 0, a0);
    chk("accept_after_reset", a0, rel + 1);
    wait_idle();
    chk("post_reset_spikes", int'(bus.spikes), 1);
    check_mem();

    // randomized ticks
    for (int t = 0; t < 24; t++) begin
      do_tick({$urandom, $urandom}, ($urandom % 3) == 0, $urandom_range(30, 255),
              $urandom_range(0, 7), a0);
      if (t % 6 == 5) begin wait_idle(); check_mem(); end
    end
    wait_idle(); check_mem();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
